// File: rtl/gcd_job_arbiter.sv
// Round-robin arbiter sharing one GCD core between NREQ requesters.
// Optional WAIT timeout enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_job_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 5,
    parameter int TO_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic              core_start,
    output logic [W-1:0]      core_a,
    output logic [W-1:0]      core_b,
    input  logic              core_done,
    input  logic [W-1:0]      core_result,
    output logic              err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  gnt_q;
    logic [IDW-1:0]  last_q;
    logic [NREQ-1:0] ack_q;
    logic [W-1:0]    result_q;
    logic [W-1:0]    core_a_q;
    logic [W-1:0]    core_b_q;
    logic            busy_q;
    logic            start_q;

    logic            gnt_ok;
    logic [IDW-1:0]  gnt_d;
    logic [W-1:0]    a_d;
    logic [W-1:0]    b_d;
    int              idx;

    // Scan downwards so the nearest requester after last_q wins.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_d  = '0;
        idx    = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = int'(last_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx[IDW-1:0]]) begin
                gnt_ok = 1'b1;
                gnt_d  = idx[IDW-1:0];
            end
        end
    end

    assign a_d = a_in[gnt_d*W +: W];
    assign b_d = b_in[gnt_d*W +: W];

`ifdef GCD_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q;
    logic          err_q;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            last_q   <= IDW'(NREQ - 1);
            ack_q    <= '0;
            result_q <= '0;
            core_a_q <= '0;
            core_b_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ack_q   <= '0;
            start_q <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (gnt_ok) begin
                        gnt_q    <= gnt_d;
                        core_a_q <= a_d;
                        core_b_q <= b_d;
                        busy_q   <= 1'b1;
                        if (a_d == '0 || b_d == '0) begin
                            result_q <= a_d | b_d;
                            ack_q    <= NREQ'(1) << gnt_d;
                            state_q  <= RESP;
                        end else begin
                            start_q  <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
`ifdef GCD_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        result_q <= core_result;
                        ack_q    <= NREQ'(1) << gnt_q;
                        state_q  <= RESP;
`ifdef GCD_ARB_TIMEOUT_EN
                    end else if (cnt_q == CW'(TO_CYCLES - 1)) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        ack_q    <= NREQ'(1) << gnt_q;
                        state_q  <= RESP;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    last_q  <= gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign core_start = start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
`ifdef GCD_ARB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Scoreboard bench for gcd_job_arbiter with a delayed GCD core model.
// Timeout checks follow GCD_ARB_TIMEOUT_EN.
module tb_gcd_job_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 5;

    logic              CLK = 1'b0;
    logic              Reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic              busy;
    logic              core_start;
    logic [W-1:0]      core_a;
    logic [W-1:0]      core_b;
    logic              core_done;
    logic [W-1:0]      core_result;
    logic              err;

    gcd_job_arbiter #(.NREQ(NREQ), .W(W), .TO_CYCLES(16)) dut (
        .CLK(CLK), .Reset(Reset), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .result(result), .busy(busy), .core_start(core_start),
        .core_a(core_a), .core_b(core_b), .core_done(core_done),
        .core_result(core_result), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         id;
        logic [W-1:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   acks = 0;
    int   starts = 0;

    // core model
    int         core_delay = 3;
    bit         core_dead = 0;
    int         m_cnt = 0;
    logic       m_done = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] st_a = '0;
    logic [W-1:0] st_b = '0;
    logic       spur_done = 1'b0;
    logic [W-1:0] spur_res = '0;

    assign core_done   = m_done | spur_done;
    assign core_result = spur_done ? spur_res : m_res;

    function automatic logic [W-1:0] gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a, b, t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(negedge CLK) begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
        end
        if (core_start === 1'b1) begin
            starts++;
            st_a = core_a;
            st_b = core_b;
            if (!core_dead) begin
                m_res = gcd(core_a, core_b);
                m_cnt = core_delay;
            end
        end
    end

    always @(negedge CLK) begin
        if (Reset) begin
            if (ack !== '0 || core_start !== 1'b0) begin
                checks++;
                if ($countones(ack) > 1 || (core_start !== 1'b0 && ack !== '0)) begin
                    errors++;
                    $display("FAIL onehot: ack=%b core_start=%b", ack, core_start);
                end
            end
            if (ack !== '0) begin
                acks++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack=%b result=%0d", ack, result);
                end else begin
                    mon_e = sb.pop_front();
                    if (ack !== (4'(1) << mon_e.id) || result !== mon_e.res || err !== mon_e.err) begin
                        errors++;
                        $display("FAIL sb_ack: got ack=%b res=%0d err=%b want ack=%b res=%0d err=%b",
                                 ack, result, err, 4'(1) << mon_e.id, mon_e.res, mon_e.err);
                    end
                end
            end
        end
    end

    task automatic push(input int id, input int r, input logic e);
        exp_t x;
        x.id  = id;
        x.res = W'(r);
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic set_job(input int id, input int a, input int b);
        a_in[id*W +: W] = W'(a);
        b_in[id*W +: W] = W'(b);
    endtask

    task automatic wait_ack(output bit ok, output int n);
        ok = 0;
        n = 0;
        while (n < 200 && !ok) begin
            @(negedge CLK);
            n++;
            if (ack !== '0) ok = 1;
        end
    endtask

    task automatic wait_start(output bit ok);
        int n;
        ok = 0;
        n = 0;
        while (n < 200 && !ok) begin
            @(negedge CLK);
            n++;
            if (core_start === 1'b1) ok = 1;
        end
    endtask

    task automatic do_reset();
        req = '0;
        spur_done = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({ack, result, busy, core_start, core_a, core_b, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: ack=%b res=%0d busy=%b st=%b a=%0d b=%0d err=%b",
                     ack, result, busy, core_start, core_a, core_b, err);
        end
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        int n;
        int s0;
        core_delay = 3;
        s0 = starts;
        @(negedge CLK);
        push(0, 5, 1'b0);
        set_job(0, 10, 5);
        req = 4'b0001;
        wait_ack(ok, n);
        req = '0;
        checks++;
        if (!ok || n != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d negedges ok=%0d want 5", n, ok);
        end
        checks++;
        if (starts - s0 != 1 || st_a !== 5'd10 || st_b !== 5'd5) begin
            errors++;
            $display("FAIL single_start: starts=%0d a=%0d b=%0d want 1,10,5", starts - s0, st_a, st_b);
        end
        @(negedge CLK);
        checks++;
        if (ack !== '0 || result !== 5'd5) begin
            errors++;
            $display("FAIL single_pulse: ack=%b res=%0d want 0000,5", ack, result);
        end
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 1, 2, 3, 0, 1};
        bit ok;
        int n;
        do_reset();
        core_delay = 2;
        push(0, 4, 0); push(1, 5, 0); push(2, 7, 0);
        push(3, 9, 0); push(0, 6, 0); push(1, 5, 0);
        set_job(0, 12, 8); set_job(1, 15, 10);
        set_job(2, 21, 14); set_job(3, 9, 27);
        req = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            wait_ack(ok, n);
            checks++;
            if (!ok || ack !== (4'(1) << order[j])) begin
                errors++;
                $display("FAIL fair_order: job %0d ack=%b want %b", j, ack, 4'(1) << order[j]);
            end
            if (j == 0) set_job(0, 30, 18);
            else if (j == 1) set_job(1, 25, 15);
            else req[order[j]] = 1'b0;
            @(negedge CLK);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL fair_gap: job %0d busy=%b want 0", j, busy);
            end
            if (j < 5) begin
                @(negedge CLK);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fair_busy: job %0d busy=%b want 1", j, busy);
                end
            end
        end
    endtask

    task automatic test_bypass();
        int vb[2] = '{12, 0};
        bit ok;
        int n;
        int s0;
        for (int k = 0; k < 2; k++) begin
            s0 = starts;
            push(1, vb[k], 0);
            set_job(1, 0, vb[k]);
            req = 4'b0010;
            wait_ack(ok, n);
            req = '0;
            checks++;
            if (!ok || n != 1 || starts != s0) begin
                errors++;
                $display("FAIL bypass: b=%0d n=%0d starts=%0d want n=1 starts=0", vb[k], n, starts - s0);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int n;
        int a0;
        core_delay = 8;
        set_job(0, 9, 6);
        req = 4'b0001;
        wait_start(ok);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        checks++;
        if (!ok || {ack, result, busy, core_start, core_a, core_b, err} !== '0) begin
            errors++;
            $display("FAIL reset_async: ack=%b res=%0d busy=%b a=%0d b=%0d", ack, result, busy, core_a, core_b);
        end
        req = '0;
        @(negedge CLK);
        Reset = 1'b1;
        a0 = acks;
        n = 0;
        while (n < 50 && m_done !== 1'b1) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (n >= 50 || acks != a0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_done: n=%0d acks=%0d busy=%b want no ack, idle", n, acks - a0, busy);
        end
        core_delay = 2;
        push(0, 3, 0);
        push(2, 7, 0);
        set_job(2, 7, 21);
        req = 4'b0101;
        wait_ack(ok, n);
        req[0] = 1'b0;
        checks++;
        if (!ok || ack !== 4'b0001) begin
            errors++;
            $display("FAIL rearb_first: ack=%b want 0001", ack);
        end
        wait_ack(ok, n);
        req[2] = 1'b0;
        checks++;
        if (!ok || ack !== 4'b0100) begin
            errors++;
            $display("FAIL rearb_second: ack=%b want 0100", ack);
        end
        @(negedge CLK);
    endtask

    task automatic test_spurious();
        bit ok;
        int n;
        int a0;
        a0 = acks;
        spur_res = 5'd31;
        spur_done = 1'b1;
        repeat (3) @(negedge CLK);
        spur_done = 1'b0;
        checks++;
        if (acks != a0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle: acks=%0d busy=%b want 0,0", acks - a0, busy);
        end
        core_delay = 4;
        push(3, 6, 0);
        set_job(3, 12, 18);
        req = 4'b1000;
        wait_start(ok);
        spur_done = 1'b1;
        req = '0;
        @(negedge CLK);
        spur_done = 1'b0;
        wait_ack(ok, n);
        checks++;
        if (!ok || ack !== 4'b1000 || result !== 5'd6) begin
            errors++;
            $display("FAIL dropped_job: ack=%b res=%0d want 1000,6", ack, result);
        end
        repeat (6) @(negedge CLK);
        checks++;
        if (acks - a0 != 1) begin
            errors++;
            $display("FAIL spur_acks: got %0d acks want 1", acks - a0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        core_dead = 1;
        set_job(1, 8, 12);
`ifdef GCD_ARB_TIMEOUT_EN
        push(1, 0, 1'b1);
        req = 4'b0010;
        wait_start(ok);
        wait_ack(ok, n);
        req = '0;
        checks++;
        if (!ok || n != 17 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: n=%0d err=%b want 17,1", n, err);
        end
`else
        req = 4'b0010;
        wait_start(ok);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (busy !== 1'b1 || err !== 1'b0 || ack !== '0) n++;
        end
        checks++;
        if (!ok || n != 0) begin
            errors++;
            $display("FAIL no_timeout: bad cycles=%0d want 0", n);
        end
        push(1, 4, 1'b0);
        spur_res = 5'd4;
        spur_done = 1'b1;
        wait_ack(ok, n);
        spur_done = 1'b0;
        req = '0;
        checks++;
        if (!ok || n != 1) begin
            errors++;
            $display("FAIL late_done: n=%0d want 1", n);
        end
`endif
        core_dead = 0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_bypass();
        test_reset_mid_job();
        test_spurious();
        test_timeout();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
